// File: rtl/fim_axis_register.sv
// fim_axis_register: single-stage AXI-Stream register slice.
//   MODE 0: skid buffer (registered s_tready), MODE 1: pipeline register,
//   MODE 2: combinational bypass.
// Optional: define OFS_FIM_AXIS_REGISTER_ASSERT_EN to compile in
// simulation-only protocol assertions.
module fim_axis_register #(
   parameter int unsigned MODE           = 0,
   parameter bit          TREADY_RST_VAL = 1'b0,
   parameter bit          ENABLE_TKEEP   = 1'b1,
   parameter bit          ENABLE_TLAST   = 1'b1,
   parameter bit          ENABLE_TID     = 1'b0,
   parameter bit          ENABLE_TDEST   = 1'b0,
   parameter bit          ENABLE_TUSER   = 1'b1,
   parameter int unsigned TDATA_WIDTH    = 512,
   parameter int unsigned TID_WIDTH      = 8,
   parameter int unsigned TDEST_WIDTH    = 8,
   parameter int unsigned TUSER_WIDTH    = 10,
   parameter string       PRESERVE_REG   = "OFF",
   parameter int unsigned REG_IN         = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,

   input  logic                     s_tvalid,
   output logic                     s_tready,
   input  logic [TDATA_WIDTH-1:0]   s_tdata,
   input  logic [TDATA_WIDTH/8-1:0] s_tkeep,
   input  logic                     s_tlast,
   input  logic [TID_WIDTH-1:0]     s_tid,
   input  logic [TDEST_WIDTH-1:0]   s_tdest,
   input  logic [TUSER_WIDTH-1:0]   s_tuser,

   output logic                     m_tvalid,
   input  logic                     m_tready,
   output logic [TDATA_WIDTH-1:0]   m_tdata,
   output logic [TDATA_WIDTH/8-1:0] m_tkeep,
   output logic                     m_tlast,
   output logic [TID_WIDTH-1:0]     m_tid,
   output logic [TDEST_WIDTH-1:0]   m_tdest,
   output logic [TUSER_WIDTH-1:0]   m_tuser
);

   localparam int unsigned KEEP_W   = TDATA_WIDTH / 8;
   localparam int unsigned OFS_KEEP = TDATA_WIDTH;
   localparam int unsigned OFS_LAST = OFS_KEEP + KEEP_W;
   localparam int unsigned OFS_ID   = OFS_LAST + 1;
   localparam int unsigned OFS_DEST = OFS_ID + TID_WIDTH;
   localparam int unsigned OFS_USER = OFS_DEST + TDEST_WIDTH;
   localparam int unsigned PL_W     = OFS_USER + TUSER_WIDTH;
   localparam bit          PRESERVE_ON = (PRESERVE_REG == "ON");

   // Only the combinational input path is implemented.
   if (REG_IN != 0) begin : g_reg_in_check
      $error("fim_axis_register: REG_IN=%0d is not supported", REG_IN);
   end

   logic [PL_W-1:0] s_pl_c;
   logic [PL_W-1:0] m_pl_c;
   logic            m_valid_c;
   logic            s_ready_c;

   // Pack the sink payload; disabled fields are forced to zero.
   always_comb begin
      s_pl_c                        = '0;
      s_pl_c[TDATA_WIDTH-1:0]       = s_tdata;
      s_pl_c[OFS_KEEP +: KEEP_W]    = s_tkeep & {KEEP_W{ENABLE_TKEEP}};
      s_pl_c[OFS_LAST]              = s_tlast & ENABLE_TLAST;
      s_pl_c[OFS_ID +: TID_WIDTH]   = s_tid & {TID_WIDTH{ENABLE_TID}};
      s_pl_c[OFS_DEST +: TDEST_WIDTH] = s_tdest & {TDEST_WIDTH{ENABLE_TDEST}};
      s_pl_c[OFS_USER +: TUSER_WIDTH] = s_tuser & {TUSER_WIDTH{ENABLE_TUSER}};
   end

   if (MODE == 2) begin : g_bypass
      assign m_valid_c = s_tvalid;
      assign m_pl_c    = s_pl_c;
      assign s_ready_c = m_tready;
   end else if (MODE == 1) begin : g_pipe
      if (PRESERVE_ON) begin : g_r
         (* preserve *) logic [PL_W-1:0] data_q;
         (* preserve *) logic            valid_q;
      end else begin : g_r
         logic [PL_W-1:0] data_q;
         logic            valid_q;
      end

      logic ready_q;
      logic valid_d;
      logic ready_c;
      logic in_xfer_c;

      // Accept whenever the register is empty or being drained this cycle.
      always_comb begin
         ready_c   = ready_q & (~g_r.valid_q | m_tready);
         in_xfer_c = s_tvalid & ready_c;
         valid_d   = g_r.valid_q;
         if (ready_c) begin
            valid_d = s_tvalid;
         end
      end

      // Control state; ready_q holds the reset ready value until the first edge.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            g_r.valid_q <= 1'b0;
            ready_q     <= TREADY_RST_VAL;
         end else begin
            g_r.valid_q <= valid_d;
            ready_q     <= 1'b1;
         end
      end

      // Payload register, not reset.
      always_ff @(posedge clk) begin
         if (in_xfer_c) begin
            g_r.data_q <= s_pl_c;
         end
      end

      assign m_valid_c = g_r.valid_q;
      assign m_pl_c    = g_r.data_q;
      assign s_ready_c = ready_c;
   end else begin : g_skid
      if (PRESERVE_ON) begin : g_r
         (* preserve *) logic [PL_W-1:0] main_q;
         (* preserve *) logic [PL_W-1:0] skid_q;
         (* preserve *) logic            main_valid_q;
         (* preserve *) logic            skid_valid_q;
      end else begin : g_r
         logic [PL_W-1:0] main_q;
         logic [PL_W-1:0] skid_q;
         logic            main_valid_q;
         logic            skid_valid_q;
      end

      logic s_ready_q;
      logic s_ready_d;
      logic main_valid_d;
      logic skid_valid_d;
      logic in_xfer_c;
      logic main_free_c;
      logic load_main_c;
      logic load_skid_c;
      logic main_from_skid_c;

      // Steer accepted beats into main or skid and refill main from skid.
      always_comb begin
         in_xfer_c        = s_tvalid & s_ready_q;
         main_free_c      = ~g_r.main_valid_q | m_tready;
         main_valid_d     = g_r.main_valid_q;
         skid_valid_d     = g_r.skid_valid_q;
         load_main_c      = 1'b0;
         load_skid_c      = 1'b0;
         main_from_skid_c = 1'b0;
         if (main_free_c) begin
            if (g_r.skid_valid_q) begin
               main_from_skid_c = 1'b1;
               main_valid_d     = 1'b1;
               skid_valid_d     = in_xfer_c;
               load_skid_c      = in_xfer_c;
            end else begin
               load_main_c  = in_xfer_c;
               main_valid_d = in_xfer_c;
            end
         end else if (in_xfer_c) begin
            load_skid_c  = 1'b1;
            skid_valid_d = 1'b1;
         end
         s_ready_d = ~skid_valid_d;
      end

      // Control state with asynchronous reset.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            g_r.main_valid_q <= 1'b0;
            g_r.skid_valid_q <= 1'b0;
            s_ready_q        <= TREADY_RST_VAL;
         end else begin
            g_r.main_valid_q <= main_valid_d;
            g_r.skid_valid_q <= skid_valid_d;
            s_ready_q        <= s_ready_d;
         end
      end

      // Payload registers, not reset.
      always_ff @(posedge clk) begin
         if (main_from_skid_c) begin
            g_r.main_q <= g_r.skid_q;
         end else if (load_main_c) begin
            g_r.main_q <= s_pl_c;
         end
         if (load_skid_c) begin
            g_r.skid_q <= s_pl_c;
         end
      end

      assign m_valid_c = g_r.main_valid_q;
      assign m_pl_c    = g_r.main_q;
      assign s_ready_c = s_ready_q;

`ifdef OFS_FIM_AXIS_REGISTER_ASSERT_EN
      // Skid must never be overwritten while it still holds a beat.
      a_skid_overwrite: assert property (@(posedge clk) disable iff (!rst_n)
         !(load_skid_c && g_r.skid_valid_q && !main_from_skid_c))
         else $error("fim_axis_register: skid register written while full");
`endif
   end

   // Unpack the master payload; disabled fields drive zero.
   assign m_tvalid = m_valid_c;
   assign s_tready = s_ready_c;
   assign m_tdata  = m_pl_c[TDATA_WIDTH-1:0];
   assign m_tkeep  = m_pl_c[OFS_KEEP +: KEEP_W] & {KEEP_W{ENABLE_TKEEP}};
   assign m_tlast  = m_pl_c[OFS_LAST] & ENABLE_TLAST;
   assign m_tid    = m_pl_c[OFS_ID +: TID_WIDTH] & {TID_WIDTH{ENABLE_TID}};
   assign m_tdest  = m_pl_c[OFS_DEST +: TDEST_WIDTH] & {TDEST_WIDTH{ENABLE_TDEST}};
   assign m_tuser  = m_pl_c[OFS_USER +: TUSER_WIDTH] & {TUSER_WIDTH{ENABLE_TUSER}};

`ifdef OFS_FIM_AXIS_REGISTER_ASSERT_EN
   // Valid may only drop after a completed handshake.
   a_valid_drop: assert property (@(posedge clk) disable iff (!rst_n)
      $fell(m_tvalid) |-> $past(m_tready))
      else $error("fim_axis_register: m_tvalid fell without handshake");

   // Payload must hold while stalled.
   a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (m_tvalid && !m_tready) |=> $stable(m_pl_c))
      else $error("fim_axis_register: m_* payload changed while stalled");

   // Handshake outputs must be known once out of reset.
   a_known: assert property (@(posedge clk) disable iff (!rst_n)
      !$isunknown({m_tvalid, s_tready}))
      else $error("fim_axis_register: m_tvalid or s_tready is X");
`endif

endmodule

// File: tb/tb_fim_axis_register.sv
// Bench for fim_axis_register: four instances (skid/RV1, pipe/RV0,
// skid/RV0 with tid disabled, bypass) driven by shared stimulus and checked
// against queue-based models plus hand-computed expectations.
module tb_fim_axis_register;

   localparam int unsigned DW  = 32;
   localparam int unsigned KW  = DW / 8;
   localparam int unsigned IW  = 8;
   localparam int unsigned DSW = 8;
   localparam int unsigned UW  = 10;
   localparam int unsigned N   = 4;
   localparam int unsigned RAND_BEATS = 10000;
   localparam int unsigned RAND_MAX_CYC = 60000;

   typedef struct packed {
      logic [UW-1:0]  user;
      logic [DSW-1:0] dest;
      logic [IW-1:0]  id;
      logic           last;
      logic [KW-1:0]  keep;
      logic [DW-1:0]  data;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst_n;
   logic  s_tvalid;
   logic  m_tready;
   beat_t s_beat;

   logic           s_rdy  [N];
   logic           m_vld  [N];
   logic [DW-1:0]  m_data [N];
   logic [KW-1:0]  m_keep [N];
   logic           m_last [N];
   logic [IW-1:0]  m_id   [N];
   logic [DSW-1:0] m_dest [N];
   logic [UW-1:0]  m_user [N];
   beat_t          m_beat [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      fim_axis_register #(
         .MODE           (g == 1 ? 1 : (g == 3 ? 2 : 0)),
         .TREADY_RST_VAL (g == 0 || g == 3 ? 1'b1 : 1'b0),
         .ENABLE_TKEEP   (1'b1),
         .ENABLE_TLAST   (1'b1),
         .ENABLE_TID     (g == 2 ? 1'b0 : 1'b1),
         .ENABLE_TDEST   (1'b1),
         .ENABLE_TUSER   (1'b1),
         .TDATA_WIDTH    (DW),
         .TID_WIDTH      (IW),
         .TDEST_WIDTH    (DSW),
         .TUSER_WIDTH    (UW),
         .PRESERVE_REG   (g == 0 ? "ON" : "OFF"),
         .REG_IN         (0)
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .s_tvalid (s_tvalid),
         .s_tready (s_rdy[g]),
         .s_tdata  (s_beat.data),
         .s_tkeep  (s_beat.keep),
         .s_tlast  (s_beat.last),
         .s_tid    (s_beat.id),
         .s_tdest  (s_beat.dest),
         .s_tuser  (s_beat.user),
         .m_tvalid (m_vld[g]),
         .m_tready (m_tready),
         .m_tdata  (m_data[g]),
         .m_tkeep  (m_keep[g]),
         .m_tlast  (m_last[g]),
         .m_tid    (m_id[g]),
         .m_tdest  (m_dest[g]),
         .m_tuser  (m_user[g])
      );
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         m_beat[i] = {m_user[i], m_dest[i], m_id[i], m_last[i], m_keep[i], m_data[i]};
      end
   end

   // ---------------- checking helpers ----------------
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each registered instance is a FIFO of held beats: the skid slice holds
   // at most two (ready while fewer than two are held), the pipeline at most one.
   beat_t       q0[$];
   beat_t       q1[$];
   beat_t       q2[$];
   bit          started;
   int unsigned n_out0;
   bit          in_x  [3];
   bit          out_x [3];

   function automatic int unsigned size_of(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic beat_t front_of(input int i);
      case (i)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   function automatic bit exp_sready(input int i);
      bit rv;
      rv = (i == 0);
      if (!started) return rv;
      if (i == 1) return (size_of(i) == 0) || m_tready;
      return size_of(i) < 2;
   endfunction

   function automatic beat_t tid_off(input beat_t b);
      beat_t r;
      r    = b;
      r.id = '0;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         q2.delete();
         started = 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            in_x[i]  = s_tvalid && exp_sready(i);
            out_x[i] = (size_of(i) != 0) && m_tready;
         end
         if (out_x[0]) begin
            void'(q0.pop_front());
            n_out0++;
         end
         if (out_x[1]) void'(q1.pop_front());
         if (out_x[2]) void'(q2.pop_front());
         if (in_x[0]) q0.push_back(s_beat);
         if (in_x[1]) q1.push_back(s_beat);
         if (in_x[2]) q2.push_back(tid_off(s_beat));
         started = 1'b1;
      end
   end

   // Every cycle: compare all instances against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         check($sformatf("d%0d_sready", i), 64'(s_rdy[i]), 64'(exp_sready(i)));
         check($sformatf("d%0d_mvalid", i), 64'(m_vld[i]), 64'(size_of(i) != 0));
         if (size_of(i) != 0) begin
            check($sformatf("d%0d_payload", i), 64'(m_beat[i]), 64'(front_of(i)));
         end
      end
      check("d3_mvalid", 64'(m_vld[3]), 64'(s_tvalid));
      check("d3_sready", 64'(s_rdy[3]), 64'(m_tready));
      check("d3_payload", 64'(m_beat[3]), 64'(s_beat));
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit v, input logic [31:0] d, input bit mr);
      @(posedge clk);
      #1;
      s_tvalid    = v;
      m_tready    = mr;
      s_beat.data = d;
      s_beat.keep = 4'hF;
      s_beat.last = (d == 32'd4);
      s_beat.id   = 8'hFF;
      s_beat.dest = d[7:0];
      s_beat.user = 10'(d);
   endtask

   int unsigned base;
   int unsigned cyc;

   initial begin
      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      m_tready = 1'b0;
      s_beat   = '0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sready_rv1", 64'(s_rdy[0]), 64'd1);
      check("rst_sready_pipe_rv0", 64'(s_rdy[1]), 64'd0);
      check("rst_sready_skid_rv0", 64'(s_rdy[2]), 64'd0);
      check("rst_mvalid0", 64'(m_vld[0]), 64'd0);
      check("rst_mvalid1", 64'(m_vld[1]), 64'd0);

      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      m_tready = 1'b1;
      @(negedge clk);
      check("post_rst_pre_edge_rv0", 64'(s_rdy[2]), 64'd0);
      check("post_rst_pre_edge_rv1", 64'(s_rdy[0]), 64'd1);
      @(negedge clk);
      check("post_rst_edge_skid", 64'(s_rdy[2]), 64'd1);
      check("post_rst_edge_pipe", 64'(s_rdy[1]), 64'd1);

      // Back-to-back streaming 1..100, tlast on beat 4 only
      for (int k = 1; k <= 100; k++) begin
         step(1'b1, 32'(k), 1'b1);
         @(negedge clk);
         check("stream_sready", 64'(s_rdy[0]), 64'd1);
         check("byp_data", 64'(m_data[3]), 64'(k));
         if (k > 1) begin
            check("stream_mvalid", 64'(m_vld[0]), 64'd1);
            check("stream_data", 64'(m_data[0]), 64'(k - 1));
            check("stream_tlast", 64'(m_last[0]), 64'((k - 1) == 4));
            check("tid_enabled", 64'(m_id[0]), 64'hFF);
            check("tid_disabled", 64'(m_id[2]), 64'd0);
         end
      end
      step(1'b0, 32'd0, 1'b1);
      @(negedge clk);
      check("stream_last_data", 64'(m_data[0]), 64'd100);
      step(1'b0, 32'd0, 1'b1);
      @(negedge clk);
      check("stream_drained", 64'(m_vld[0]), 64'd0);

      // Backpressure: 1 held on m, 2 in skid, 3 waits
      step(1'b1, 32'd1, 1'b0);
      @(negedge clk);
      check("byp_sready_low", 64'(s_rdy[3]), 64'd0);
      step(1'b1, 32'd2, 1'b0);
      @(negedge clk);
      check("bp_hold1_valid", 64'(m_vld[0]), 64'd1);
      check("bp_hold1_data", 64'(m_data[0]), 64'd1);
      check("bp_sready_before_skid", 64'(s_rdy[0]), 64'd1);
      step(1'b1, 32'd3, 1'b0);
      @(negedge clk);
      check("bp_stall_data", 64'(m_data[0]), 64'd1);
      check("bp_sready_skid_full", 64'(s_rdy[0]), 64'd0);
      step(1'b1, 32'd3, 1'b0);
      @(negedge clk);
      check("bp_stall_data2", 64'(m_data[0]), 64'd1);
      check("bp_sready_held_low", 64'(s_rdy[0]), 64'd0);
      step(1'b1, 32'd3, 1'b1);
      @(negedge clk);
      check("bp_release_pre", 64'(m_data[0]), 64'd1);
      check("bp_release_pre_sready", 64'(s_rdy[0]), 64'd0);
      step(1'b1, 32'd3, 1'b1);
      @(negedge clk);
      check("bp_release_data2", 64'(m_data[0]), 64'd2);
      check("bp_release_sready", 64'(s_rdy[0]), 64'd1);
      step(1'b0, 32'd0, 1'b1);
      @(negedge clk);
      check("bp_data3", 64'(m_data[0]), 64'd3);
      check("bp_data3_valid", 64'(m_vld[0]), 64'd1);
      step(1'b0, 32'd0, 1'b1);
      @(negedge clk);
      check("bp_empty", 64'(m_vld[0]), 64'd0);

      // Reset mid-stream with beats held
      step(1'b1, 32'd9, 1'b0);
      step(1'b1, 32'd10, 1'b0);
      @(negedge clk);
      check("mid_rst_held", 64'(m_vld[0]), 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_mvalid0", 64'(m_vld[0]), 64'd0);
      check("mid_rst_mvalid1", 64'(m_vld[1]), 64'd0);
      check("mid_rst_sready_rv1", 64'(s_rdy[0]), 64'd1);
      check("mid_rst_sready_rv0", 64'(s_rdy[2]), 64'd0);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      @(negedge clk);
      check("mid_rst_pre_edge", 64'(s_rdy[2]), 64'd0);
      @(negedge clk);
      check("mid_rst_recovered", 64'(s_rdy[2]), 64'd1);
      check("mid_rst_empty", 64'(m_vld[0]), 64'd0);

      // Random 50% valid / 50% ready traffic
      base = n_out0;
      cyc  = 0;
      while ((n_out0 - base) < RAND_BEATS && cyc < RAND_MAX_CYC) begin
         @(posedge clk);
         #1;
         s_tvalid    = 1'($urandom_range(0, 1));
         m_tready    = 1'($urandom_range(0, 1));
         s_beat.data = $urandom;
         s_beat.keep = KW'($urandom);
         s_beat.last = 1'($urandom);
         s_beat.id   = IW'($urandom);
         s_beat.dest = DSW'($urandom);
         s_beat.user = UW'($urandom);
         cyc++;
      end
      check("rand_beat_budget", 64'((n_out0 - base) >= RAND_BEATS), 64'd1);

      step(1'b0, 32'd0, 1'b1);
      step(1'b0, 32'd0, 1'b1);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fim_axis_register.md
# fim_axis_register

Single-stage AXI-Stream register slice for FIM datapaths. It breaks timing paths on the forward (data/valid) path and, in skid mode, on the backward (tready) path. Three modes are supported: skid buffer, simple pipeline register, or pass-through. It is used stand-alone and chained inside longer skid pipelines that rely on its exact ready timing.

## Interface
- MODE, 0: 0 = skid buffer, 1 = simple pipeline register, 2 = bypass (wires).
- TREADY_RST_VAL, 0: s_tready value while rst_n is low (0 or 1).
- ENABLE_TKEEP, 1: carry tkeep.
- ENABLE_TLAST, 1: carry tlast.
- ENABLE_TID, 0: carry tid.
- ENABLE_TDEST, 0: carry tdest.
- ENABLE_TUSER, 1: carry tuser.
- TDATA_WIDTH, 512: data width, a multiple of 8.
- TID_WIDTH, 8; TDEST_WIDTH, 8; TUSER_WIDTH, 10: sideband widths.
- PRESERVE_REG, "OFF": "ON" attaches a preserve-register synthesis attribute to the data/valid registers. No functional effect.
- REG_IN, 0: only 0 is supported. Any other value causes an elaboration error.
- clk, input, 1: the single clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- s_tvalid/s_tready, input/output, 1 each: sink handshake.
- s_tdata, input, TDATA_WIDTH; s_tkeep, input, TDATA_WIDTH/8; s_tlast, input, 1; s_tid, input, TID_WIDTH; s_tdest, input, TDEST_WIDTH; s_tuser, input, TUSER_WIDTH.
- m_tvalid, output, 1; m_tready, input, 1; m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser: outputs, same widths as the sink side.

## Operation
- A beat transfers on a port when tvalid and tready are both 1 at a rising clk edge.
- Payload is all enabled fields. A disabled field is ignored on input and drives constant 0 on output.
- MODE 0 (skid):
  - Holds an output register (main) and a skid register, each with a valid bit.
  - s_tready is a register equal to !skid_valid.
  - On an accepted beat with main empty, or with main consumed the same cycle, the beat loads main. This applies only if skid is empty; otherwise skid moves to main and the new beat loads skid.
  - On an accepted beat while main is full and stalled (m_tready=0), the beat loads skid.
  - When main is consumed and skid is valid, skid moves to main and skid_valid clears.
  - No beat is ever dropped or duplicated. Order is preserved.
- MODE 1 (pipeline): one register. s_tready = !m_tvalid || m_tready (combinational). The register loads on an accepted beat.
- MODE 2 (bypass): m_* = s_* and s_tready = m_tready, all combinational.
- Payload registers hold their value while m_tvalid=1 and m_tready=0.

## Timing
- Reset, asynchronous, while rst_n=0:
  - m_tvalid = 0 and the skid valid bit is cleared.
  - s_tready = TREADY_RST_VAL (MODE 0 and 1).
  - Payload registers are not reset.
- First rising edge after rst_n deasserts: s_tready = 1 (MODE 0).
- Latency is 1 cycle s→m in MODE 0 and 1, and 0 in MODE 2. Full throughput is 1 beat/cycle with m_tready held at 1.
- MODE 0 stall: with m_tvalid=1 and m_tready=0, one further beat is accepted into skid. s_tready falls at the next edge. A beat presented in the cycle when s_tready=1 is always absorbed.
- MODE 0 release: the cycle after m_tready rises, skid drains into main and s_tready returns to 1 at that edge.
- Reset mid-stream: all held beats are discarded and m_tvalid drops immediately.

## Configuration
- OFS_FIM_AXIS_REGISTER_ASSERT_EN defined: simulation-only assertions are compiled in. They fire $error when:
  - m_tvalid falls without a handshake,
  - m_* payload changes while stalled,
  - m_tvalid or s_tready is X out of reset,
  - the skid register is written while full.
- Macro not defined: no assertion logic. Function is identical.

## Test plan
- Streaming, MODE 0, m_tready=1, send data 1..100 back-to-back → m sees 1..100, each one cycle later, s_tready constantly 1.
- Backpressure, MODE 0: send 1,2,3 with m_tready=0 from cycle 1 → 1 is held on m, 2 is in skid, s_tready=0 after 2 is accepted. Raise m_tready → output 1,2,3 in order, s_tready=1 one cycle after release.
- Reset, TREADY_RST_VAL=1 → during reset s_tready=1 and m_tvalid=0. After deassert, s_tready=1. Repeat with TREADY_RST_VAL=0 → s_tready=0 during reset.
- Random tvalid/tready with 50% duty, all fields enabled, 10k beats, MODE 0 and 1 → scoreboard matches exactly, stalled payload is stable.
- ENABLE_TID=0 with s_tid=8'hFF → m_tid=0. ENABLE_TLAST=1, tlast on beat 4 → m_tlast=1 only on beat 4.
- MODE 2 → m_tdata equals s_tdata in the same cycle and s_tready equals m_tready combinationally.
